mem_test_master: RTL
====================

// Module: mem_test_master
// PURPOSE
// - Initiator for the memory valid/ready request interface.
// - On start_i it performs two passes over the memory:
//   - Write pass: writes a deterministic pattern to every address 0..DEPTH-1.
//   - Read pass: reads every address back and compares it against the pattern.
// - Reports done, pass/fail, error count, first failing address and timeout.
// - Sits beside the memory as its built-in self-test / bring-up controller.
// PARAMETERS
// - WIDTH       16             data word width, bits
// - DEPTH       512            number of words tested
// - ADDR_WIDTH  $clog2(DEPTH)  address width
// - SEED        16'hA5C3       pattern seed, WIDTH bits
// - TIMEOUT     64             max stall cycles per transfer; 0 disables the timeout
// PORTS
// - clk_i             in   1             clock, rising edge
// - rst_i             in   1             asynchronous reset, active-high
// - start_i           in   1             pulse; starts a test run
// - busy_o            out  1             run in progress
// - done_o            out  1             run finished; sticky until next start
// - pass_o            out  1             valid with done_o; 1 = no errors and no timeout
// - timeout_o         out  1             run aborted on a stalled transfer
// - err_count_o       out  ADDR_WIDTH+1  number of read mismatches
// - first_err_addr_o  out  ADDR_WIDTH    address of the first mismatch; 0 if none
// - addr_o            out  ADDR_WIDTH    request address
// - wdata_o           out  WIDTH         write data
// - wr_rd_o           out  1             1 = write, 0 = read
// - valid_o           out  1             request valid
// - ready_i           in   1             memory accepts / completes the request
// - rdata_i           in   WIDTH         read data; valid on the cycle a read completes
// BEHAVIOUR
// - Reset (async, any state): FSM goes to IDLE; every output is 0.
// - FSM states: IDLE -> WRITE -> READ -> DONE.
//   - IDLE/DONE + start_i: clear status, enter WRITE, addr = 0, busy_o = 1.
//   - start_i is ignored while busy_o = 1.
// - Handshake:
//   - A transfer completes on a rising edge where valid_o && ready_i.
//   - addr_o, wdata_o and wr_rd_o are held stable from valid_o rise until completion.
//   - valid_o never drops before completion, except on timeout abort or reset.
// - Back-to-back transfers: after a completion, the next request is presented
//   on the following cycle and valid_o stays high.
//   - The WRITE->READ switch (after addr DEPTH-1 is written) is seamless:
//     the next cycle shows addr_o = 0, wr_rd_o = 0, valid_o = 1.
// - Pattern: pat(a) = zero-extended a ^ SEED.
//   - If ADDR_WIDTH > WIDTH, a is truncated to WIDTH bits.
//   - wdata_o = pat(addr_o) during WRITE; wdata_o = 0 during READ.
// - Compare:
//   - On each read completion, rdata_i != pat(addr_o) increments err_count_o.
//   - The first mismatch of a run captures addr_o into first_err_addr_o.
//   - err_count_o maximum is DEPTH, so it needs no saturation.
// - Completion: after the read of DEPTH-1 completes, the next cycle has
//   valid_o = 0, busy_o = 0, done_o = 1, pass_o = (err_count_o == 0).
// - Timeout:
//   - A stall counter increments each cycle with valid_o && !ready_i.
//   - It clears on every completion.
//   - On reaching TIMEOUT, the next cycle has valid_o = 0, state = DONE,
//     done_o = 1, timeout_o = 1, pass_o = 0.
//   - err_count_o and first_err_addr_o keep their values.
// - Status outputs hold in DONE until the next start_i or reset.
//   - A new start clears done_o, pass_o, timeout_o, err_count_o and first_err_addr_o.
// - Reset mid-run: the run is abandoned immediately (valid_o drops
//   asynchronously); no status is retained.
// TESTING
// - T1 Always-ready memory, DEPTH=512, start_i pulse:
//   -> 512 writes, then 512 reads, 1024 consecutive valid cycles.
//   -> done_o = 1 and pass_o = 1 exactly 1 cycle after the last read; err_count_o = 0.
// - T2 Memory model corrupts addr 5 and addr 300 (bit 0 flipped):
//   -> err_count_o = 2, first_err_addr_o = 5, pass_o = 0.
// - T3 ready_i randomly deasserted (50%):
//   -> addr_o, wdata_o and wr_rd_o stable during every stall.
//   -> Write to addr 3 carries wdata_o = 16'hA5C0; the run passes.
// - T4 ready_i held low from the write to addr 10, TIMEOUT=64:
//   -> after 64 stall cycles: valid_o = 0, done_o = 1, timeout_o = 1, pass_o = 0.
// - T5 rst_i asserted mid-READ at addr 200:
//   -> all outputs 0 asynchronously.
//   -> A new start_i runs a full pass with fresh status (err_count_o restarts at 0).
// - T6 start_i pulsed while busy_o = 1:
//   -> ignored; address sequence and result are unchanged.

Source files
------------

// File: rtl/mem_test_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_test_master
// Description : Built-in self-test master for a valid/ready memory port.
//               A start pulse runs a write pass that fills addresses
//               0..DEPTH-1 with pat(a) = a ^ SEED, then a read pass that
//               checks every word. It reports done, pass/fail, the mismatch
//               count, the first failing address and a stall timeout.
//
// Ports
//   clk_i            : clock, rising edge
//   rst_i            : asynchronous reset, active-high
//   start_i          : start pulse, ignored while busy_o is high
//   busy_o           : run in progress
//   done_o           : run finished, sticky until the next start
//   pass_o           : valid with done_o; no mismatches and no timeout
//   timeout_o        : run aborted on a stalled transfer
//   err_count_o      : number of read mismatches
//   first_err_addr_o : address of the first mismatch (0 if none)
//   addr_o           : request address
//   wdata_o          : write data (0 during the read pass)
//   wr_rd_o          : 1 = write, 0 = read
//   valid_o          : request valid
//   ready_i          : memory accepts / completes the request
//   rdata_i          : read data, valid on the read completion cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_test_master #(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 512,
    parameter int               ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] SEED       = 16'hA5C3,
    parameter int               TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_WRITE = 2'd1;
    localparam logic [1:0] c_S_READ  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // The stall counter only ever holds 0..TIMEOUT-1: the cycle that would
    // take it to TIMEOUT aborts the run instead of incrementing.
    localparam int c_STALL_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_STALL_LIM_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [c_STALL_W-1:0] c_STALL_LIM = c_STALL_LIM_I[c_STALL_W-1:0];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [ADDR_WIDTH:0]   r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_err_addr;
    logic [c_STALL_W-1:0]  r_stall_cnt;

    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_done_nxt;
    logic                  w_pass_nxt;
    logic                  w_timeout_nxt;
    logic [ADDR_WIDTH:0]   w_err_count_nxt;
    logic [ADDR_WIDTH-1:0] w_first_err_addr_nxt;
    logic [c_STALL_W-1:0]  w_stall_cnt_nxt;

    logic                  w_valid;
    logic                  w_write;
    logic                  w_xfer;
    logic                  w_stall_hit;
    logic                  w_last;
    logic [WIDTH-1:0]      w_addr_ext;
    logic [WIDTH-1:0]      w_pat;

    // ------------------------------------------------------------------------
    // Pattern: address zero-extended (or truncated) to WIDTH, xor SEED
    // ------------------------------------------------------------------------
    generate
        if (ADDR_WIDTH >= WIDTH) begin : g_pat_trunc
            assign w_addr_ext = r_addr[WIDTH-1:0];
        end else begin : g_pat_ext
            assign w_addr_ext = {{(WIDTH - ADDR_WIDTH){1'b0}}, r_addr};
        end
    endgenerate

    assign w_pat = w_addr_ext ^ SEED;

    // A request is outstanding in every cycle of the two passes; this is what
    // makes transfers back-to-back and the write->read switch seamless.
    assign w_valid     = (r_state == c_S_WRITE) || (r_state == c_S_READ);
    assign w_write     = (r_state == c_S_WRITE);
    assign w_xfer      = w_valid && ready_i;
    assign w_last      = (r_addr == c_LAST_ADDR);
    assign w_stall_hit = (TIMEOUT != 0) && w_valid && !ready_i &&
                         (r_stall_cnt == c_STALL_LIM);

    // ------------------------------------------------------------------------
    // Next-state and status logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt          = r_state;
        w_addr_nxt           = r_addr;
        w_done_nxt           = r_done;
        w_pass_nxt           = r_pass;
        w_timeout_nxt        = r_timeout;
        w_err_count_nxt      = r_err_count;
        w_first_err_addr_nxt = r_first_err_addr;
        w_stall_cnt_nxt      = '0;

        if (w_valid && !ready_i) begin
            w_stall_cnt_nxt = r_stall_cnt + c_STALL_W'(1);
        end

        case (r_state)
            c_S_IDLE, c_S_DONE: begin
                if (start_i) begin
                    w_state_nxt          = c_S_WRITE;
                    w_addr_nxt           = '0;
                    w_done_nxt           = 1'b0;
                    w_pass_nxt           = 1'b0;
                    w_timeout_nxt        = 1'b0;
                    w_err_count_nxt      = '0;
                    w_first_err_addr_nxt = '0;
                end
            end

            c_S_WRITE: begin
                if (w_stall_hit) begin
                    w_state_nxt     = c_S_DONE;
                    w_addr_nxt      = '0;
                    w_done_nxt      = 1'b1;
                    w_timeout_nxt   = 1'b1;
                    w_pass_nxt      = 1'b0;
                    w_stall_cnt_nxt = '0;
                end else if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt = c_S_READ;
                        w_addr_nxt  = '0;
                    end else begin
                        w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end

            c_S_READ: begin
                if (w_stall_hit) begin
                    w_state_nxt     = c_S_DONE;
                    w_addr_nxt      = '0;
                    w_done_nxt      = 1'b1;
                    w_timeout_nxt   = 1'b1;
                    w_pass_nxt      = 1'b0;
                    w_stall_cnt_nxt = '0;
                end else if (w_xfer) begin
                    if (rdata_i != w_pat) begin
                        // At most DEPTH mismatches fit in ADDR_WIDTH+1 bits.
                        w_err_count_nxt = r_err_count + (ADDR_WIDTH + 1)'(1);
                        if (r_err_count == '0) begin
                            w_first_err_addr_nxt = r_addr;
                        end
                    end
                    if (w_last) begin
                        w_state_nxt = c_S_DONE;
                        w_addr_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_count_nxt == '0);
                    end else begin
                        w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state          <= c_S_IDLE;
            r_addr           <= '0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_stall_cnt      <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_addr           <= w_addr_nxt;
            r_done           <= w_done_nxt;
            r_pass           <= w_pass_nxt;
            r_timeout        <= w_timeout_nxt;
            r_err_count      <= w_err_count_nxt;
            r_first_err_addr <= w_first_err_addr_nxt;
            r_stall_cnt      <= w_stall_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded from state so reset drops the request immediately)
    // ------------------------------------------------------------------------
    assign busy_o           = w_valid;
    assign valid_o          = w_valid;
    assign wr_rd_o          = w_write;
    assign addr_o           = r_addr;
    assign wdata_o          = w_write ? w_pat : '0;
    assign done_o           = r_done;
    assign pass_o           = r_pass;
    assign timeout_o        = r_timeout;
    assign err_count_o      = r_err_count;
    assign first_err_addr_o = r_first_err_addr;

endmodule
`default_nettype wire
